// File: rtl/riscv_uart_programmer.sv
// UART-side initiator for the memories' upg write port: receives 8N1 frames,
// issues one-cycle word writes and answers each frame with ACK/NAK on tx.
module riscv_uart_programmer #(
  parameter int CLK_FREQ       = 10000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic [2:0]  dbg_state_o
);

  localparam int          DIV     = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [31:0] TMO_M1  = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [2:0] P_IDLE = 3'd0, P_ADR1 = 3'd1, P_ADR0 = 3'd2,
                         P_DAT  = 3'd3, P_CHK  = 3'd4, P_DONE = 3'd5;
  localparam logic [7:0] HDR = 8'hA5, DONE_CMD = 8'h5A, ACK = 8'h06, NAK = 8'h15;

  // Receiver
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]  r_state_q;
  logic [15:0] r_cnt_q;
  logic [2:0]  r_bit_q;
  logic [7:0]  r_shift_q;
  logic        byte_valid_q, frame_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      r_state_q <= R_IDLE; r_cnt_q <= '0; r_bit_q <= '0; r_shift_q <= '0;
      byte_valid_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      r_cnt_q      <= r_cnt_q + 16'd1;
      case (r_state_q)
        R_IDLE: begin
          r_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) r_state_q <= R_START;
        end
        R_START: if (r_cnt_q == HALF_M1) begin
          r_cnt_q   <= '0;
          r_bit_q   <= '0;
          r_state_q <= rx_s2_q ? R_IDLE : R_DATA;
        end
        R_DATA: if (r_cnt_q == DIV_M1) begin
          r_cnt_q   <= '0;
          r_shift_q <= {rx_s2_q, r_shift_q[7:1]};
          r_bit_q   <= r_bit_q + 3'd1;
          if (r_bit_q == 3'd7) r_state_q <= R_STOP;
        end
        default: if (r_cnt_q == DIV_M1) begin
          byte_valid_q <= rx_s2_q;
          frame_err_q  <= !rx_s2_q;
          r_state_q    <= R_IDLE;
        end
      endcase
    end
  end

  // Frame parser
  logic [2:0]  p_state_q, p_state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [13:0] adr_q, adr_d, upg_adr_q, upg_adr_d;
  logic [31:0] dat_q, dat_d, upg_dat_q, upg_dat_d, tmo_q, tmo_d;
  logic [7:0]  chk_q, chk_d, resp_code_q, resp_code_d;
  logic        upg_rst_q, upg_rst_d, upg_wen_q, upg_wen_d, upg_done_q, upg_done_d;
  logic        resp_req_q, resp_req_d, in_frame;

  assign in_frame = (p_state_q != P_IDLE) && (p_state_q != P_DONE);

  always_comb begin
    p_state_d = p_state_q; byte_cnt_d = byte_cnt_q; adr_d = adr_q; dat_d = dat_q;
    chk_d = chk_q; upg_adr_d = upg_adr_q; upg_dat_d = upg_dat_q; upg_rst_d = upg_rst_q;
    upg_done_d = upg_done_q; resp_code_d = resp_code_q;
    upg_wen_d = 1'b0; resp_req_d = 1'b0;
    tmo_d = (in_frame && !byte_valid_q) ? tmo_q + 32'd1 : 32'd0;
    if (frame_err_q && p_state_q != P_DONE) begin
      p_state_d = P_IDLE;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_IDLE: if (r_shift_q == HDR) begin
          upg_rst_d = 1'b0; chk_d = '0; p_state_d = P_ADR1;
        end else if (r_shift_q == DONE_CMD) begin
          upg_done_d = 1'b1; upg_rst_d = 1'b1;
          resp_req_d = 1'b1; resp_code_d = ACK; p_state_d = P_DONE;
        end
        P_ADR1: begin
          adr_d[13:8] = r_shift_q[5:0]; chk_d = chk_q ^ r_shift_q; p_state_d = P_ADR0;
        end
        P_ADR0: begin
          adr_d[7:0] = r_shift_q; chk_d = chk_q ^ r_shift_q;
          byte_cnt_d = '0; p_state_d = P_DAT;
        end
        P_DAT: begin
          // Little-endian: D3 ends up in the top byte after four shifts.
          dat_d = {r_shift_q, dat_q[31:8]}; chk_d = chk_q ^ r_shift_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) p_state_d = P_CHK;
        end
        P_CHK: begin
          resp_req_d = 1'b1; p_state_d = P_IDLE;
          if (r_shift_q == chk_q) begin
            upg_adr_d = adr_q; upg_dat_d = dat_q; upg_wen_d = 1'b1; resp_code_d = ACK;
          end else begin
            resp_code_d = NAK;
          end
        end
        P_DONE: ;
        default: p_state_d = P_IDLE;
      endcase
    end else if (in_frame && tmo_q == TMO_M1) begin
      p_state_d = P_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state_q <= P_IDLE; byte_cnt_q <= '0; adr_q <= '0; dat_q <= '0; chk_q <= '0;
      tmo_q <= '0; upg_adr_q <= '0; upg_dat_q <= '0; upg_rst_q <= 1'b1;
      upg_wen_q <= 1'b0; upg_done_q <= 1'b0; resp_req_q <= 1'b0; resp_code_q <= '0;
    end else begin
      p_state_q <= p_state_d; byte_cnt_q <= byte_cnt_d; adr_q <= adr_d; dat_q <= dat_d;
      chk_q <= chk_d; tmo_q <= tmo_d; upg_adr_q <= upg_adr_d; upg_dat_q <= upg_dat_d;
      upg_rst_q <= upg_rst_d; upg_wen_q <= upg_wen_d; upg_done_q <= upg_done_d;
      resp_req_q <= resp_req_d; resp_code_q <= resp_code_d;
    end
  end

  // Transmitter with a one-entry pending slot; a new request overwrites it.
  logic        pend_q, t_busy_q, tx_q;
  logic [7:0]  pend_byte_q;
  logic [8:0]  t_shift_q;
  logic [3:0]  t_bits_q;
  logic [15:0] t_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0; pend_byte_q <= '0; t_busy_q <= 1'b0; tx_q <= 1'b1;
      t_shift_q <= '0; t_bits_q <= '0; t_cnt_q <= '0;
    end else begin
      if (resp_req_q) begin
        pend_q <= 1'b1; pend_byte_q <= resp_code_q;
      end else if (!t_busy_q && pend_q) begin
        pend_q <= 1'b0;
      end
      if (!t_busy_q) begin
        if (pend_q) begin
          t_busy_q <= 1'b1; tx_q <= 1'b0; t_shift_q <= {1'b1, pend_byte_q};
          t_bits_q <= 4'd9; t_cnt_q <= '0;
        end
      end else if (t_cnt_q == DIV_M1) begin
        t_cnt_q <= '0;
        if (t_bits_q == 4'd0) begin
          t_busy_q <= 1'b0; tx_q <= 1'b1;
        end else begin
          tx_q <= t_shift_q[0]; t_shift_q <= {1'b0, t_shift_q[8:1]};
          t_bits_q <= t_bits_q - 4'd1;
        end
      end else begin
        t_cnt_q <= t_cnt_q + 16'd1;
      end
    end
  end

  assign tx          = tx_q;
  assign upg_rst_o   = upg_rst_q;
  assign upg_wen_o   = upg_wen_q;
  assign upg_adr_o   = upg_adr_q;
  assign upg_dat_o   = upg_dat_q;
  assign upg_done_o  = upg_done_q;
  assign dbg_state_o = p_state_q;

endmodule

// File: tb/tb_riscv_uart_programmer.sv
// Bench for riscv_uart_programmer: UART byte driver, write and tx monitors
// that pop expected results from scoreboard queues, and scenario tasks.
module tb_riscv_uart_programmer;

  localparam int CLK_FREQ = 10000000;
  localparam int BAUD     = 625000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TMO      = 3000;

  logic        clk, rst, rx, tx;
  logic        upg_rst_o, upg_wen_o, upg_done_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic [2:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [45:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];

  riscv_uart_programmer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .upg_rst_o(upg_rst_o), .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  logic wen_prev = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1 && upg_wen_o === 1'b1) begin
      n_cmp++;
      if (wen_prev) begin
        n_err++;
        $display("FAIL wen_width: strobe high for more than one cycle, required 1");
      end else if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: adr=%04h dat=%08h, no write expected", upg_adr_o, upg_dat_o);
      end else begin
        logic [45:0] e;
        e = exp_wr_q.pop_front();
        if ({upg_adr_o, upg_dat_o} !== e)
          begin
            n_err++;
            $display("FAIL wr_data: adr=%04h dat=%08h, required adr=%04h dat=%08h",
                     upg_adr_o, upg_dat_o, e[45:32], e[31:0]);
          end
      end
    end
    wen_prev = upg_wen_o;
  end

  // TX monitor: decodes 8N1 bytes at mid-bit and checks against the queue.
  initial begin : tx_mon
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
          n_err++;
          $display("FAIL tx_stop: stop bit=%b, required 1", tx);
        end
        n_cmp++;
        if (exp_tx_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: byte %02h sent, none expected", b);
        end else begin
          e = exp_tx_q.pop_front();
          if (b !== e) begin
            n_err++;
            $display("FAIL tx_byte: sent %02h, required %02h", b, e);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
    if (bad_stop) repeat (DIV) @(posedge clk);
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] ahi, alo, input logic [31:0] d);
    return ahi ^ alo ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  task automatic send_frame(input logic [7:0] ahi, alo, input logic [31:0] d,
                            input logic [7:0] chk_flip);
    logic [7:0] fr[8];
    fr[0] = 8'hA5; fr[1] = ahi; fr[2] = alo;
    fr[3] = d[7:0]; fr[4] = d[15:8]; fr[5] = d[23:16]; fr[6] = d[31:24];
    fr[7] = calc_chk(ahi, alo, d) ^ chk_flip;
    for (int i = 0; i < 8; i++) send_byte(fr[i], 1'b0);
  endtask

  task automatic push_good(input logic [7:0] ahi, alo, input logic [31:0] d);
    exp_wr_q.push_back({ahi[5:0], alo, d});
    exp_tx_q.push_back(8'h06);
  endtask

  // Bounded wait until the monitors have consumed every expected event.
  task automatic wait_drain(output bit ok);
    int c = 0;
    while ((exp_wr_q.size() != 0 || exp_tx_q.size() != 0) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    ok = (exp_wr_q.size() == 0 && exp_tx_q.size() == 0);
    exp_wr_q.delete();
    exp_tx_q.delete();
    repeat (DIV) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset;
    bit bad = 1'b0;
    rst = 1'b0; rx = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({tx, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, dbg_state_o}
        !== {1'b1, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_vals: tx=%b rst=%b wen=%b adr=%04h dat=%08h done=%b st=%0d, required 1 1 0 0000 00000000 0 0",
               tx, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, dbg_state_o);
    end
    @(posedge clk); rst = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || upg_wen_o !== 1'b0 || upg_rst_o !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL idle_quiet: tx/wen/upg_rst moved while rx idle, required 1/0/1");
    end
  endtask

  task automatic test_good_frame;
    bit ok;
    push_good(8'h00, 8'h12, 32'hDEADBEEF);
    send_byte(8'hA5, 1'b0);
    n_cmp++;
    if (upg_rst_o !== 1'b0) begin
      n_err++;
      $display("FAIL upg_rst_fall: upg_rst_o=%b after header, required 0", upg_rst_o);
    end
    send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
    send_byte(8'h30, 1'b0);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL good_frame_drain: expected write/ACK missing, required both seen");
    end
    n_cmp++;
    if ({upg_adr_o, upg_dat_o} !== {14'h0012, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL held_outputs: adr=%04h dat=%08h, required 0012 DEADBEEF", upg_adr_o, upg_dat_o);
    end
  endtask

  task automatic test_bad_checksum;
    bit ok;
    exp_tx_q.push_back(8'h15);
    send_frame(8'h00, 8'h12, 32'hDEADBEEF, 8'h01);
    push_good(8'h00, 8'h34, 32'h01234567);
    send_frame(8'h00, 8'h34, 32'h01234567, 8'h00);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL bad_chk_drain: NAK or recovery write missing, required both seen");
    end
  endtask

  task automatic test_timeout;
    bit ok;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'hEF, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    n_cmp++;
    if (dbg_state_o !== 3'd0 || upg_rst_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_state: state=%0d upg_rst=%b, required 0 0", dbg_state_o, upg_rst_o);
    end
    push_good(8'h00, 8'h12, 32'hCAFEF00D);
    send_frame(8'h00, 8'h12, 32'hCAFEF00D, 8'h00);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL timeout_recover: write/ACK after timeout missing, required both seen");
    end
  endtask

  task automatic test_stop_error;
    bit ok;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
    send_byte(8'h30, 1'b0);
    repeat (4 * DIV) @(negedge clk);
    n_cmp++;
    if (dbg_state_o !== 3'd0) begin
      n_err++;
      $display("FAIL stop_err_state: state=%0d, required 0", dbg_state_o);
    end
    push_good(8'h01, 8'h00, 32'h55AA33CC);
    send_frame(8'h01, 8'h00, 32'h55AA33CC, 8'h00);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stop_err_recover: write/ACK missing, required both seen");
    end
  endtask

  task automatic test_glitch;
    bit ok;
    @(posedge clk); rx = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    push_good(8'h3F, 8'hFF, 32'h89ABCDEF);
    send_frame(8'h3F, 8'hFF, 32'h89ABCDEF, 8'h00);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL glitch: frame after glitch not written, required write and ACK");
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] ahi, alo;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      ahi = 8'($urandom_range(0, 255));
      alo = 8'($urandom_range(0, 255));
      d   = $urandom();
      push_good(ahi, alo, d);
      send_frame(ahi, alo, d, 8'h00);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL back_to_back: not all writes/ACKs seen, required 3 of each");
    end
  endtask

  task automatic test_done;
    bit ok;
    exp_tx_q.push_back(8'h06);
    send_byte(8'h5A, 1'b0);
    n_cmp++;
    if (upg_done_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_flags: done=%b upg_rst=%b, required 1 1", upg_done_o, upg_rst_o);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL done_ack: ACK for done command missing, required 06");
    end
    send_frame(8'h00, 8'h12, 32'hDEADBEEF, 8'h00);
    repeat (400) @(negedge clk);
    n_cmp++;
    if (dbg_state_o !== 3'd5 || upg_done_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_terminal: state=%0d done=%b upg_rst=%b, required 5 1 1",
               dbg_state_o, upg_done_o, upg_rst_o);
    end
  endtask

  task automatic test_reset_mid_frame;
    @(posedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    n_cmp++;
    if (upg_rst_o !== 1'b0 || dbg_state_o !== 3'd2) begin
      n_err++;
      $display("FAIL mid_frame: upg_rst=%b state=%0d, required 0 2", upg_rst_o, dbg_state_o);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, dbg_state_o}
        !== {1'b1, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid: tx=%b rst=%b wen=%b adr=%04h dat=%08h done=%b st=%0d, required 1 1 0 0000 00000000 0 0",
               tx, upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, dbg_state_o);
    end
    @(posedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_done();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
